// File: rtl/axis_demux_2.sv
// Packet-aware 1-to-2 AXI-Stream demultiplexer: each whole packet is steered to
// output 1 or 2 by sel, sampled on the first beat, with per-output packet counters.
module axis_demux_2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] DATA_in,
  input  logic                  TVALID_in,
  input  logic                  TLAST_in,
  output logic                  TREADY_in,
  output logic [DATA_WIDTH-1:0] DATA_out_1,
  output logic                  TVALID_out_1,
  output logic                  TLAST_out_1,
  input  logic                  TREADY_out_1,
  output logic [DATA_WIDTH-1:0] DATA_out_2,
  output logic                  TVALID_out_2,
  output logic                  TLAST_out_2,
  input  logic                  TREADY_out_2,
  output logic [CNT_WIDTH-1:0]  PKT_CNT_1,
  output logic [CNT_WIDTH-1:0]  PKT_CNT_2
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_route;
  logic                  w_route_nxt;
  logic                  w_route;
  logic                  w_accept;
  logic                  w_load_1;
  logic                  w_load_2;
  logic                  w_xfer_1;
  logic                  w_xfer_2;

  logic [DATA_WIDTH-1:0] r_data_1;
  logic                  r_valid_1;
  logic                  r_last_1;
  logic [DATA_WIDTH-1:0] r_data_2;
  logic                  r_valid_2;
  logic                  r_last_2;
  logic [CNT_WIDTH-1:0]  r_cnt_1;
  logic [CNT_WIDTH-1:0]  r_cnt_2;

  // A packet's route is live from sel until its first beat is taken, then locked.
  assign w_route   = (r_state == S_IDLE) ? sel : r_route;
  assign TREADY_in = w_route ? (!r_valid_2 || TREADY_out_2)
                             : (!r_valid_1 || TREADY_out_1);
  assign w_accept  = TVALID_in && TREADY_in;
  assign w_load_1  = w_accept && !w_route;
  assign w_load_2  = w_accept &&  w_route;
  assign w_xfer_1  = r_valid_1 && TREADY_out_1;
  assign w_xfer_2  = r_valid_2 && TREADY_out_2;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_route <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_route <= w_route_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_route_nxt = r_route;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !TLAST_in) begin
          w_state_nxt = S_BUSY;
          w_route_nxt = sel;
        end
      end
      S_BUSY: begin
        if (w_accept && TLAST_in) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output stage 1: a load always wins over a drain in the same cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_data_1  <= '0;
      r_valid_1 <= 1'b0;
      r_last_1  <= 1'b0;
    end else if (w_load_1) begin
      r_data_1  <= DATA_in;
      r_valid_1 <= 1'b1;
      r_last_1  <= TLAST_in;
    end else if (w_xfer_1) begin
      r_valid_1 <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_data_2  <= '0;
      r_valid_2 <= 1'b0;
      r_last_2  <= 1'b0;
    end else if (w_load_2) begin
      r_data_2  <= DATA_in;
      r_valid_2 <= 1'b1;
      r_last_2  <= TLAST_in;
    end else if (w_xfer_2) begin
      r_valid_2 <= 1'b0;
    end
  end

  // Completed-packet counters wrap naturally.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
    end else begin
      if (w_xfer_1 && r_last_1) r_cnt_1 <= r_cnt_1 + CNT_WIDTH'(1);
      if (w_xfer_2 && r_last_2) r_cnt_2 <= r_cnt_2 + CNT_WIDTH'(1);
    end
  end

  assign DATA_out_1   = r_data_1;
  assign TVALID_out_1 = r_valid_1;
  assign TLAST_out_1  = r_last_1;
  assign DATA_out_2   = r_data_2;
  assign TVALID_out_2 = r_valid_2;
  assign TLAST_out_2  = r_last_2;
  assign PKT_CNT_1    = r_cnt_1;
  assign PKT_CNT_2    = r_cnt_2;

endmodule

// File: tb/tb_axis_demux_2.sv
// Bench for axis_demux_2: directed scenarios plus a randomized run against a
// queue-based packet model (CNT_WIDTH = 4 so counter wrap is reachable).
module tb_axis_demux_2;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          ACLK;
  logic          ARESETn;
  logic          sel;
  logic [DW-1:0] DATA_in;
  logic          TVALID_in;
  logic          TLAST_in;
  logic          TREADY_in;
  logic [DW-1:0] DATA_out_1;
  logic          TVALID_out_1;
  logic          TLAST_out_1;
  logic          TREADY_out_1;
  logic [DW-1:0] DATA_out_2;
  logic          TVALID_out_2;
  logic          TLAST_out_2;
  logic          TREADY_out_2;
  logic [CW-1:0] PKT_CNT_1;
  logic [CW-1:0] PKT_CNT_2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  axis_demux_2 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .sel(sel),
    .DATA_in(DATA_in), .TVALID_in(TVALID_in), .TLAST_in(TLAST_in), .TREADY_in(TREADY_in),
    .DATA_out_1(DATA_out_1), .TVALID_out_1(TVALID_out_1), .TLAST_out_1(TLAST_out_1),
    .TREADY_out_1(TREADY_out_1),
    .DATA_out_2(DATA_out_2), .TVALID_out_2(TVALID_out_2), .TLAST_out_2(TLAST_out_2),
    .TREADY_out_2(TREADY_out_2),
    .PKT_CNT_1(PKT_CNT_1), .PKT_CNT_2(PKT_CNT_2)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic idle_inputs();
    sel = 1'b0; DATA_in = '0; TVALID_in = 1'b0; TLAST_in = 1'b0;
    TREADY_out_1 = 1'b1; TREADY_out_2 = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESETn = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({TVALID_out_1, TLAST_out_1, DATA_out_1, TVALID_out_2, TLAST_out_2, DATA_out_2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v1=%b l1=%b d1=%h v2=%b l2=%b d2=%h required all 0",
               TVALID_out_1, TLAST_out_1, DATA_out_1, TVALID_out_2, TLAST_out_2, DATA_out_2);
    end
    checks++;
    if (PKT_CNT_1 !== 4'd0 || PKT_CNT_2 !== 4'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d required 0/0", PKT_CNT_1, PKT_CNT_2);
    end
    checks++;
    if (TREADY_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready got %b required 1", TREADY_in);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      TVALID_in = 1'b1; DATA_in = 8'(8'h11 + i); TLAST_in = (i == 3);
      #1;
      checks++;
      if (TREADY_in !== 1'b1) begin
        errors++; $display("FAIL basic_tready beat %0d got %b required 1", i, TREADY_in);
      end
      @(negedge ACLK);
      checks++;
      if (TVALID_out_1 !== 1'b1 || DATA_out_1 !== 8'(8'h11 + i) || TLAST_out_1 !== (i == 3)
          || TVALID_out_2 !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat %0d got v1=%b d1=%h l1=%b v2=%b required v1=1 d1=%h l1=%b v2=0",
                 i, TVALID_out_1, DATA_out_1, TLAST_out_1, TVALID_out_2, 8'(8'h11 + i), (i == 3));
      end
    end
    TVALID_in = 1'b0; TLAST_in = 1'b0;
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_1 !== 4'd1 || PKT_CNT_2 !== 4'd0 || TVALID_out_1 !== 1'b0) begin
      errors++;
      $display("FAIL basic_count got cnt1=%0d cnt2=%0d v1=%b required 1 0 0",
               PKT_CNT_1, PKT_CNT_2, TVALID_out_1);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0); TVALID_in = 1'b1; DATA_in = 8'(8'hA0 + i); TLAST_in = (i == 2);
      @(negedge ACLK);
      checks++;
      if (TVALID_out_2 !== 1'b1 || DATA_out_2 !== 8'(8'hA0 + i) || TVALID_out_1 !== 1'b0) begin
        errors++;
        $display("FAIL lock_beat %0d got v2=%b d2=%h v1=%b required v2=1 d2=%h v1=0",
                 i, TVALID_out_2, DATA_out_2, TVALID_out_1, 8'(8'hA0 + i));
      end
    end
    sel = 1'b0; DATA_in = 8'hB0; TLAST_in = 1'b1;
    @(negedge ACLK);
    checks++;
    if (TVALID_out_1 !== 1'b1 || DATA_out_1 !== 8'hB0 || TVALID_out_2 !== 1'b0 || PKT_CNT_2 !== 4'd1) begin
      errors++;
      $display("FAIL lock_next got v1=%b d1=%h v2=%b cnt2=%0d required 1 b0 0 1",
               TVALID_out_1, DATA_out_1, TVALID_out_2, PKT_CNT_2);
    end
    TVALID_in = 1'b0; TLAST_in = 1'b0;
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_1 !== 4'd1) begin
      errors++; $display("FAIL lock_cnt1 got %0d required 1", PKT_CNT_1);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] obs[$];
    int idx;
    do_reset();
    TREADY_out_1 = 1'b0;
    TVALID_in = 1'b1; DATA_in = 8'hC0; TLAST_in = 1'b0;
    #1;
    checks++;
    if (TREADY_in !== 1'b1) begin
      errors++; $display("FAIL bp_first_tready got %b required 1", TREADY_in);
    end
    @(negedge ACLK);
    DATA_in = 8'hC1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (TREADY_in !== 1'b0 || TVALID_out_1 !== 1'b1 || DATA_out_1 !== 8'hC0) begin
        errors++;
        $display("FAIL bp_stall cycle %0d got tready=%b v1=%b d1=%h required 0 1 c0",
                 c, TREADY_in, TVALID_out_1, DATA_out_1);
      end
      @(negedge ACLK);
    end
    TREADY_out_1 = 1'b1;
    idx = 1;
    for (int c = 0; c < 30 && obs.size() < 4; c++) begin
      TVALID_in = (idx < 4); DATA_in = 8'(8'hC0 + idx); TLAST_in = (idx == 3);
      #1;
      if (TVALID_out_1 && TREADY_out_1) obs.push_back(DATA_out_1);
      if (TVALID_in && TREADY_in) idx++;
      @(negedge ACLK);
    end
    TVALID_in = 1'b0; TLAST_in = 1'b0;
    checks++;
    if (obs.size() != 4) begin
      errors++; $display("FAIL bp_beat_count got %0d required 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs[i] !== 8'(8'hC0 + i)) begin
          errors++; $display("FAIL bp_order beat %0d got %h required %h", i, obs[i], 8'(8'hC0 + i));
        end
      end
    end
    checks++;
    if (PKT_CNT_1 !== 4'd1) begin
      errors++; $display("FAIL bp_count got %0d required 1", PKT_CNT_1);
    end
  endtask

  task automatic test_cross();
    do_reset();
    TREADY_out_1 = 1'b0;
    sel = 1'b0; TVALID_in = 1'b1; DATA_in = 8'h55; TLAST_in = 1'b1;
    @(negedge ACLK);
    sel = 1'b1; DATA_in = 8'h66;
    #1;
    checks++;
    if (TREADY_in !== 1'b1) begin
      errors++; $display("FAIL cross_tready_out2 got %b required 1", TREADY_in);
    end
    @(negedge ACLK);
    sel = 1'b0; TVALID_in = 1'b0; TLAST_in = 1'b0;
    #1;
    checks++;
    if (TVALID_out_2 !== 1'b1 || DATA_out_2 !== 8'h66 || TVALID_out_1 !== 1'b1
        || DATA_out_1 !== 8'h55 || TREADY_in !== 1'b0) begin
      errors++;
      $display("FAIL cross_both got v2=%b d2=%h v1=%b d1=%h tready=%b required 1 66 1 55 0",
               TVALID_out_2, DATA_out_2, TVALID_out_1, DATA_out_1, TREADY_in);
    end
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_2 !== 4'd1 || TVALID_out_2 !== 1'b0 || TVALID_out_1 !== 1'b1 || PKT_CNT_1 !== 4'd0) begin
      errors++;
      $display("FAIL cross_drain2 got cnt2=%0d v2=%b v1=%b cnt1=%0d required 1 0 1 0",
               PKT_CNT_2, TVALID_out_2, TVALID_out_1, PKT_CNT_1);
    end
    TREADY_out_1 = 1'b1;
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_1 !== 4'd1 || TVALID_out_1 !== 1'b0) begin
      errors++; $display("FAIL cross_drain1 got cnt1=%0d v1=%b required 1 0", PKT_CNT_1, TVALID_out_1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    sel = 1'b1; TVALID_in = 1'b1; DATA_in = 8'h77; TLAST_in = 1'b1;
    @(negedge ACLK);
    DATA_in = 8'hD0; TLAST_in = 1'b0;
    @(negedge ACLK);
    sel = 1'b0; DATA_in = 8'hD1;
    @(negedge ACLK);
    TVALID_in = 1'b0;
    checks++;
    if (PKT_CNT_2 !== 4'd1 || TVALID_out_2 !== 1'b1 || DATA_out_2 !== 8'hD1) begin
      errors++;
      $display("FAIL rmid_pre got cnt2=%0d v2=%b d2=%h required 1 1 d1", PKT_CNT_2, TVALID_out_2, DATA_out_2);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if ({TVALID_out_1, TLAST_out_1, DATA_out_1, TVALID_out_2, TLAST_out_2, DATA_out_2,
         PKT_CNT_1, PKT_CNT_2} !== '0) begin
      errors++;
      $display("FAIL rmid_clear got v1=%b d1=%h v2=%b d2=%h l2=%b cnt=%0d/%0d required all 0",
               TVALID_out_1, DATA_out_1, TVALID_out_2, DATA_out_2, TLAST_out_2, PKT_CNT_1, PKT_CNT_2);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    sel = 1'b0; TVALID_in = 1'b1; DATA_in = 8'hE0; TLAST_in = 1'b0;
    @(negedge ACLK);
    checks++;
    if (TVALID_out_1 !== 1'b1 || DATA_out_1 !== 8'hE0 || TVALID_out_2 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_new got v1=%b d1=%h v2=%b required 1 e0 0", TVALID_out_1, DATA_out_1, TVALID_out_2);
    end
    sel = 1'b1; DATA_in = 8'hE1; TLAST_in = 1'b1;
    @(negedge ACLK);
    TVALID_in = 1'b0; TLAST_in = 1'b0;
    checks++;
    if (TVALID_out_1 !== 1'b1 || DATA_out_1 !== 8'hE1 || TVALID_out_2 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_lock got v1=%b d1=%h v2=%b required 1 e1 0", TVALID_out_1, DATA_out_1, TVALID_out_2);
    end
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_1 !== 4'd1 || PKT_CNT_2 !== 4'd0) begin
      errors++; $display("FAIL rmid_count got %0d/%0d required 1/0", PKT_CNT_1, PKT_CNT_2);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sel = 1'b0; TLAST_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      TVALID_in = 1'b1; DATA_in = 8'(i);
      @(negedge ACLK);
    end
    TVALID_in = 1'b0; TLAST_in = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    checks++;
    if (PKT_CNT_1 !== 4'd1 || PKT_CNT_2 !== 4'd0) begin
      errors++; $display("FAIL wrap_count got %0d/%0d required 1/0", PKT_CNT_1, PKT_CNT_2);
    end
  endtask

  // Packet-level model: beats queued per destination, route fixed per packet.
  task automatic test_random();
    beat_t q1[$];
    beat_t q2[$];
    beat_t b;
    bit    in_pkt;
    bit    pkt_dest;
    bit    route;
    bit    exp_tready;
    bit    acc;
    bit    x1;
    bit    x2;
    int    cnt1;
    int    cnt2;
    do_reset();
    in_pkt = 0; pkt_dest = 0; cnt1 = 0; cnt2 = 0;
    for (int n = 0; n < 420; n++) begin
      if (n < 400) begin
        TVALID_in    = ($urandom % 4) != 0;
        DATA_in      = 8'($urandom);
        TLAST_in     = ($urandom % 3) == 0;
        sel          = 1'($urandom);
        TREADY_out_1 = ($urandom % 4) != 0;
        TREADY_out_2 = ($urandom % 3) != 0;
      end else begin
        idle_inputs();
      end
      #1;
      route      = in_pkt ? pkt_dest : sel;
      exp_tready = route ? (q2.size() == 0 || TREADY_out_2) : (q1.size() == 0 || TREADY_out_1);
      acc        = TVALID_in && exp_tready;
      x1         = (q1.size() != 0) && TREADY_out_1;
      x2         = (q2.size() != 0) && TREADY_out_2;
      checks++;
      if (TREADY_in !== exp_tready) begin
        errors++; $display("FAIL rand_tready cycle %0d got %b required %b", n, TREADY_in, exp_tready);
      end
      checks++;
      if (TVALID_out_1 !== (q1.size() != 0) || TVALID_out_2 !== (q2.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid cycle %0d got %b/%b required %b/%b", n, TVALID_out_1, TVALID_out_2,
                 q1.size() != 0, q2.size() != 0);
      end
      if (q1.size() != 0) begin
        checks++;
        if (DATA_out_1 !== q1[0].d || TLAST_out_1 !== q1[0].l) begin
          errors++;
          $display("FAIL rand_out1 cycle %0d got %h/%b required %h/%b", n, DATA_out_1, TLAST_out_1,
                   q1[0].d, q1[0].l);
        end
      end
      if (q2.size() != 0) begin
        checks++;
        if (DATA_out_2 !== q2[0].d || TLAST_out_2 !== q2[0].l) begin
          errors++;
          $display("FAIL rand_out2 cycle %0d got %h/%b required %h/%b", n, DATA_out_2, TLAST_out_2,
                   q2[0].d, q2[0].l);
        end
      end
      checks++;
      if (PKT_CNT_1 !== 4'(cnt1) || PKT_CNT_2 !== 4'(cnt2)) begin
        errors++;
        $display("FAIL rand_count cycle %0d got %0d/%0d required %0d/%0d", n, PKT_CNT_1, PKT_CNT_2,
                 cnt1 % 16, cnt2 % 16);
      end
      @(posedge ACLK);
      if (x1) begin b = q1.pop_front(); if (b.l) cnt1 = (cnt1 + 1) % 16; end
      if (x2) begin b = q2.pop_front(); if (b.l) cnt2 = (cnt2 + 1) % 16; end
      if (acc) begin
        b.d = DATA_in; b.l = TLAST_in;
        if (route) q2.push_back(b); else q1.push_back(b);
        in_pkt   = !TLAST_in;
        pkt_dest = route;
      end
      @(negedge ACLK);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lock();
    test_backpressure();
    test_cross();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
